// File: rtl/seq_game_control.sv
// Control FSM for the number-sequence memory game: sequences generate, show,
// input, compare and level/life bookkeeping, and paces SHOW/INPUT on next_clk edges.
module seq_game_control #(
  parameter int MAX_LEVEL     = 7,
  parameter int TIMEOUT_TICKS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       key_press,
  input  logic       replay,
  input  logic       next_clk,
  input  logic [2:0] level,
  input  logic       seq_end,
  input  logic       end_comp,
  input  logic       show_counter_zero,
  input  logic       full_input,
  input  logic       no_lives,
  input  logic       match,
  input  logic       clk_zero,
  output logic       init_show_counter,
  output logic       reset_clk,
  output logic       init_lives,
  output logic       init_seq_counter,
  output logic       init_user_counter,
  output logic       init_level,
  output logic       init_match_counter,
  output logic       store_num,
  output logic       incr_seq_counter,
  output logic       incr_user_counter,
  output logic       read_seq,
  output logic       store_input,
  output logic       decr_show_counter,
  output logic       read_input,
  output logic       decr_lives,
  output logic       decr_clk,
  output logic       incr_level,
  output logic       show_active,
  output logic       await_input,
  output logic       game_over,
  output logic       game_won
);

  localparam int CW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_TICKS - 1);
  localparam logic [2:0]    LVL_MAX  = 3'(MAX_LEVEL);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_INIT  = 4'd1,
    ST_GEN   = 4'd2,
    ST_SHOW  = 4'd3,
    ST_INPUT = 4'd4,
    ST_CMP   = 4'd5,
    ST_JUDGE = 4'd6,
    ST_LEVEL = 4'd7,
    ST_MISS  = 4'd8,
    ST_LCHK  = 4'd9,
    ST_OVER  = 4'd10,
    ST_WON   = 4'd11
  } state_t;

  state_t        state_r, state_s;
  logic          tick_q_r;
  logic [CW-1:0] to_cnt_r;
  logic          tick_s;
  logic          key_ok_s;
  logic          timeout_s;

  assign tick_s    = next_clk & ~tick_q_r;
  assign key_ok_s  = (state_r == ST_INPUT) & ~full_input & key_press;
  assign timeout_s = (to_cnt_r == CNT_LAST) & tick_s;

  // State, edge-detect history and input timeout counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      tick_q_r <= 1'b1;
      to_cnt_r <= CNT_ZERO;
    end else begin
      state_r  <= state_s;
      tick_q_r <= next_clk;
      // Counter sits at zero outside INPUT, so entry always starts from zero
      if (state_r != ST_INPUT || state_s != ST_INPUT) begin
        to_cnt_r <= CNT_ZERO;
      end else if (key_ok_s) begin
        to_cnt_r <= CNT_ZERO;
      end else if (tick_s) begin
        to_cnt_r <= to_cnt_r + CNT_ONE;
      end else begin
        to_cnt_r <= to_cnt_r;
      end
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_s            = state_r;
    init_show_counter  = 1'b0;
    reset_clk          = 1'b0;
    init_lives         = 1'b0;
    init_seq_counter   = 1'b0;
    init_user_counter  = 1'b0;
    init_level         = 1'b0;
    init_match_counter = 1'b0;
    store_num          = 1'b0;
    incr_seq_counter   = 1'b0;
    incr_user_counter  = 1'b0;
    read_seq           = 1'b0;
    store_input        = 1'b0;
    decr_show_counter  = 1'b0;
    read_input         = 1'b0;
    decr_lives         = 1'b0;
    decr_clk           = 1'b0;
    incr_level         = 1'b0;
    case (state_r)
      ST_IDLE, ST_OVER, ST_WON: begin
        if (start) state_s = ST_INIT;
        else       state_s = state_r;
      end
      ST_INIT: begin
        init_show_counter  = 1'b1;
        reset_clk          = 1'b1;
        init_lives         = 1'b1;
        init_level         = 1'b1;
        init_seq_counter   = 1'b1;
        init_user_counter  = 1'b1;
        init_match_counter = 1'b1;
        state_s            = ST_GEN;
      end
      ST_GEN: begin
        if (seq_end) begin
          init_seq_counter = 1'b1;
          state_s          = ST_SHOW;
        end else begin
          store_num        = 1'b1;
          incr_seq_counter = 1'b1;
        end
      end
      ST_SHOW: begin
        if (tick_s && seq_end) begin
          init_seq_counter  = 1'b1;
          init_user_counter = 1'b1;
          state_s           = ST_INPUT;
        end else if (tick_s) begin
          read_seq         = 1'b1;
          incr_seq_counter = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      ST_INPUT: begin
        if (full_input) begin
          init_seq_counter   = 1'b1;
          init_user_counter  = 1'b1;
          init_match_counter = 1'b1;
          state_s            = ST_CMP;
        end else if (key_press) begin
          store_input       = 1'b1;
          incr_user_counter = 1'b1;
        end else if (replay && !show_counter_zero) begin
          decr_show_counter = 1'b1;
          init_seq_counter  = 1'b1;
          init_user_counter = 1'b1;
          state_s           = ST_SHOW;
        end else if (timeout_s) begin
          state_s = ST_MISS;
        end else begin
          state_s = state_r;
        end
      end
      ST_CMP: begin
        if (end_comp) begin
          state_s = ST_JUDGE;
        end else begin
          read_input        = 1'b1;
          incr_user_counter = 1'b1;
          incr_seq_counter  = 1'b1;
        end
      end
      ST_JUDGE: begin
        if (match) state_s = ST_LEVEL;
        else       state_s = ST_MISS;
      end
      ST_LEVEL: begin
        if (level == LVL_MAX || clk_zero) begin
          state_s = ST_WON;
        end else begin
          incr_level         = 1'b1;
          decr_clk           = 1'b1;
          init_show_counter  = 1'b1;
          init_seq_counter   = 1'b1;
          init_user_counter  = 1'b1;
          init_match_counter = 1'b1;
          state_s            = ST_GEN;
        end
      end
      ST_MISS: begin
        decr_lives = 1'b1;
        state_s    = ST_LCHK;
      end
      ST_LCHK: begin
        if (no_lives) begin
          state_s = ST_OVER;
        end else begin
          init_show_counter  = 1'b1;
          init_seq_counter   = 1'b1;
          init_user_counter  = 1'b1;
          init_match_counter = 1'b1;
          state_s            = ST_GEN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  assign show_active = (state_r == ST_SHOW);
  assign await_input = (state_r == ST_INPUT);
  assign game_over   = (state_r == ST_OVER);
  assign game_won    = (state_r == ST_WON);

endmodule

// File: tb/tb_seq_game_control.sv
// Directed bench for seq_game_control: drives datapath flags by hand and checks
// strobes/flags against hand-computed vectors, sampled half a cycle from the edge.
module tb_seq_game_control;

  logic clk = 1'b0;
  logic reset, start, key_press, replay, next_clk;
  logic [2:0] level;
  logic seq_end, end_comp, show_counter_zero, full_input, no_lives, match, clk_zero;
  logic init_show_counter, reset_clk, init_lives, init_seq_counter, init_user_counter;
  logic init_level, init_match_counter, store_num, incr_seq_counter, incr_user_counter;
  logic read_seq, store_input, decr_show_counter, read_input, decr_lives, decr_clk, incr_level;
  logic show_active, await_input, game_over, game_won;

  int vecs = 0;
  int errs = 0;

  // Strobe bits, MSB first: init_show, reset_clk, init_lives, init_seq, init_user,
  // init_level, init_match, store_num, incr_seq, incr_user, read_seq, store_input,
  // decr_show, read_input, decr_lives, decr_clk, incr_level
  localparam logic [16:0] S_NONE     = 17'h00000;
  localparam logic [16:0] S_INIT     = 17'h1FC00;
  localparam logic [16:0] S_GEN      = 17'h00300;
  localparam logic [16:0] S_INIT_SEQ = 17'h02000;
  localparam logic [16:0] S_SHOW_RD  = 17'h00140;
  localparam logic [16:0] S_SHOW_END = 17'h03000;
  localparam logic [16:0] S_IN_FULL  = 17'h03400;
  localparam logic [16:0] S_KEY      = 17'h000A0;
  localparam logic [16:0] S_REPLAY   = 17'h03010;
  localparam logic [16:0] S_CMP      = 17'h00188;
  localparam logic [16:0] S_LVL      = 17'h13403;
  localparam logic [16:0] S_MISS     = 17'h00004;
  localparam logic [16:0] S_LCHK     = 17'h13400;
  localparam logic [3:0]  F_NONE = 4'b0000;
  localparam logic [3:0]  F_SHOW = 4'b1000;
  localparam logic [3:0]  F_IN   = 4'b0100;
  localparam logic [3:0]  F_OVER = 4'b0010;
  localparam logic [3:0]  F_WON  = 4'b0001;

  logic [16:0] strb;
  logic [3:0]  flags;
  assign strb = {init_show_counter, reset_clk, init_lives, init_seq_counter, init_user_counter,
                 init_level, init_match_counter, store_num, incr_seq_counter, incr_user_counter,
                 read_seq, store_input, decr_show_counter, read_input, decr_lives, decr_clk,
                 incr_level};
  assign flags = {show_active, await_input, game_over, game_won};

  always #5 clk = ~clk;

  seq_game_control #(.MAX_LEVEL(7), .TIMEOUT_TICKS(16)) dut (
    .clk(clk), .reset(reset), .start(start), .key_press(key_press), .replay(replay),
    .next_clk(next_clk), .level(level), .seq_end(seq_end), .end_comp(end_comp),
    .show_counter_zero(show_counter_zero), .full_input(full_input), .no_lives(no_lives),
    .match(match), .clk_zero(clk_zero),
    .init_show_counter(init_show_counter), .reset_clk(reset_clk), .init_lives(init_lives),
    .init_seq_counter(init_seq_counter), .init_user_counter(init_user_counter),
    .init_level(init_level), .init_match_counter(init_match_counter), .store_num(store_num),
    .incr_seq_counter(incr_seq_counter), .incr_user_counter(incr_user_counter),
    .read_seq(read_seq), .store_input(store_input), .decr_show_counter(decr_show_counter),
    .read_input(read_input), .decr_lives(decr_lives), .decr_clk(decr_clk),
    .incr_level(incr_level), .show_active(show_active), .await_input(await_input),
    .game_over(game_over), .game_won(game_won)
  );

  // Stimulus only: walk SHOW through 8 next_clk edges into INPUT (next_clk must start low)
  task automatic show_to_input();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); next_clk = 1'b1; seq_end = (i == 7);
      @(negedge clk); next_clk = 1'b0; seq_end = 1'b0;
    end
  endtask

  // Stimulus only: from GEN, finish generation and reach INPUT
  task automatic to_input();
    @(negedge clk); seq_end = 1'b1;
    show_to_input();
  endtask

  // Stimulus only: from GEN, reach CMP with end_comp raised (JUDGE follows)
  task automatic to_judge();
    to_input();
    @(negedge clk); full_input = 1'b1;
    @(negedge clk); full_input = 1'b0; end_comp = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; next_clk = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0; #1;
    vecs++; if (strb !== S_NONE) begin errs++; $display("FAIL reset_strobes got=%h exp=%h", strb, S_NONE); end
    vecs++; if (flags !== F_NONE) begin errs++; $display("FAIL reset_flags got=%b exp=%b", flags, F_NONE); end
  endtask

  task automatic test_start_gen();
    @(negedge clk); start = 1'b1; next_clk = 1'b0; #1;
    vecs++; if (strb !== S_NONE) begin errs++; $display("FAIL idle_start got=%h exp=%h", strb, S_NONE); end
    @(negedge clk); start = 1'b0; #1;
    vecs++; if (strb !== S_INIT) begin errs++; $display("FAIL init_strobes got=%h exp=%h", strb, S_INIT); end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); #1;
      vecs++; if (strb !== S_GEN) begin errs++; $display("FAIL gen_cycle%0d got=%h exp=%h", i, strb, S_GEN); end
    end
    @(negedge clk); seq_end = 1'b1; #1;
    vecs++; if (strb !== S_INIT_SEQ) begin errs++; $display("FAIL gen_end got=%h exp=%h", strb, S_INIT_SEQ); end
    @(negedge clk); seq_end = 1'b0; #1;
    vecs++; if ({flags, strb} !== {F_SHOW, S_NONE}) begin errs++; $display("FAIL show_entry got=%h exp=%h", {flags, strb}, {F_SHOW, S_NONE}); end
  endtask

  task automatic test_show();
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk); next_clk = 1'b1; seq_end = (e == 8); #1;
      vecs++;
      if (e < 8 && strb !== S_SHOW_RD) begin errs++; $display("FAIL show_edge%0d got=%h exp=%h", e, strb, S_SHOW_RD); end
      else if (e == 8 && strb !== S_SHOW_END) begin errs++; $display("FAIL show_last got=%h exp=%h", strb, S_SHOW_END); end
      @(negedge clk); seq_end = 1'b0; #1;
      vecs++; if (strb !== S_NONE) begin errs++; $display("FAIL show_level%0d got=%h exp=%h", e, strb, S_NONE); end
      @(negedge clk); next_clk = 1'b0; #1;
      vecs++; if (strb !== S_NONE) begin errs++; $display("FAIL show_low%0d got=%h exp=%h", e, strb, S_NONE); end
    end
    vecs++; if (flags !== F_IN) begin errs++; $display("FAIL show_to_input got=%b exp=%b", flags, F_IN); end
  endtask

  task automatic test_input_cmp_level();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk); key_press = 1'b1; #1;
      vecs++; if (strb !== S_KEY) begin errs++; $display("FAIL key%0d got=%h exp=%h", k, strb, S_KEY); end
      @(negedge clk); key_press = 1'b0;
    end
    @(negedge clk); full_input = 1'b1; #1;
    vecs++; if (strb !== S_IN_FULL) begin errs++; $display("FAIL full_input got=%h exp=%h", strb, S_IN_FULL); end
    @(negedge clk); full_input = 1'b0;
    for (int k = 0; k < 7; k++) begin
      #1; vecs++; if (strb !== S_CMP) begin errs++; $display("FAIL cmp%0d got=%h exp=%h", k, strb, S_CMP); end
      @(negedge clk);
    end
    end_comp = 1'b1; #1;
    vecs++; if (strb !== S_NONE) begin errs++; $display("FAIL cmp_end got=%h exp=%h", strb, S_NONE); end
    @(negedge clk); end_comp = 1'b0; match = 1'b1; #1;
    vecs++; if (strb !== S_NONE) begin errs++; $display("FAIL judge got=%h exp=%h", strb, S_NONE); end
    @(negedge clk); match = 1'b0; level = 3'd3; #1;
    vecs++; if (strb !== S_LVL) begin errs++; $display("FAIL level_up got=%h exp=%h", strb, S_LVL); end
    @(negedge clk); level = 3'd4; #1;
    vecs++; if (strb !== S_GEN) begin errs++; $display("FAIL level_to_gen got=%h exp=%h", strb, S_GEN); end
  endtask

  task automatic test_replay();
    to_input();
    @(negedge clk); replay = 1'b1; show_counter_zero = 1'b0; #1;
    vecs++; if (strb !== S_REPLAY) begin errs++; $display("FAIL replay1 got=%h exp=%h", strb, S_REPLAY); end
    @(negedge clk); replay = 1'b0; #1;
    vecs++; if (flags !== F_SHOW) begin errs++; $display("FAIL replay1_show got=%b exp=%b", flags, F_SHOW); end
    show_to_input();
    @(negedge clk); replay = 1'b1; show_counter_zero = 1'b1; #1;
    vecs++; if (strb !== S_NONE) begin errs++; $display("FAIL replay2 got=%h exp=%h", strb, S_NONE); end
    @(negedge clk); replay = 1'b0; show_counter_zero = 1'b0; #1;
    vecs++; if (flags !== F_IN) begin errs++; $display("FAIL replay2_stay got=%b exp=%b", flags, F_IN); end
    @(negedge clk); key_press = 1'b1; replay = 1'b1; #1;
    vecs++; if (strb !== S_KEY) begin errs++; $display("FAIL key_and_replay got=%h exp=%h", strb, S_KEY); end
    @(negedge clk); key_press = 1'b0; replay = 1'b0; #1;
    vecs++; if ({flags, strb} !== {F_IN, S_NONE}) begin errs++; $display("FAIL key_replay_stay got=%h exp=%h", {flags, strb}, {F_IN, S_NONE}); end
  endtask

  task automatic test_miss_lives();
    @(negedge clk); full_input = 1'b1; #1;
    vecs++; if (strb !== S_IN_FULL) begin errs++; $display("FAIL miss_full got=%h exp=%h", strb, S_IN_FULL); end
    @(negedge clk); full_input = 1'b0; end_comp = 1'b1;
    @(negedge clk); end_comp = 1'b0; match = 1'b0; #1;
    vecs++; if (strb !== S_NONE) begin errs++; $display("FAIL miss_judge got=%h exp=%h", strb, S_NONE); end
    @(negedge clk); #1;
    vecs++; if (strb !== S_MISS) begin errs++; $display("FAIL miss_pulse got=%h exp=%h", strb, S_MISS); end
    @(negedge clk); no_lives = 1'b0; #1;
    vecs++; if (strb !== S_LCHK) begin errs++; $display("FAIL lchk_alive got=%h exp=%h", strb, S_LCHK); end
    @(negedge clk); #1;
    vecs++; if (strb !== S_GEN) begin errs++; $display("FAIL lchk_to_gen got=%h exp=%h", strb, S_GEN); end
    to_judge();
    @(negedge clk); end_comp = 1'b0; match = 1'b0;
    @(negedge clk); #1;
    vecs++; if (strb !== S_MISS) begin errs++; $display("FAIL miss2_pulse got=%h exp=%h", strb, S_MISS); end
    @(negedge clk); no_lives = 1'b1; #1;
    vecs++; if (strb !== S_NONE) begin errs++; $display("FAIL lchk_dead got=%h exp=%h", strb, S_NONE); end
    @(negedge clk); no_lives = 1'b0; #1;
    vecs++; if (flags !== F_OVER) begin errs++; $display("FAIL game_over got=%b exp=%b", flags, F_OVER); end
    @(negedge clk); key_press = 1'b1; replay = 1'b1; full_input = 1'b1; #1;
    vecs++; if (strb !== S_NONE) begin errs++; $display("FAIL over_ignores got=%h exp=%h", strb, S_NONE); end
    @(negedge clk); key_press = 1'b0; replay = 1'b0; full_input = 1'b0; #1;
    vecs++; if (flags !== F_OVER) begin errs++; $display("FAIL over_hold got=%b exp=%b", flags, F_OVER); end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    vecs++; if (strb !== S_INIT) begin errs++; $display("FAIL over_restart got=%h exp=%h", strb, S_INIT); end
  endtask

  task automatic test_timeout();
    to_input();
    for (int t = 0; t < 10; t++) begin
      @(negedge clk); next_clk = 1'b1;
      @(negedge clk); next_clk = 1'b0;
    end
    @(negedge clk); key_press = 1'b1; #1;
    vecs++; if (strb !== S_KEY) begin errs++; $display("FAIL timeout_key got=%h exp=%h", strb, S_KEY); end
    @(negedge clk); key_press = 1'b0;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk); next_clk = 1'b1;
      @(negedge clk); next_clk = 1'b0;
    end
    #1; vecs++; if (flags !== F_IN) begin errs++; $display("FAIL timeout_15 got=%b exp=%b", flags, F_IN); end
    @(negedge clk); next_clk = 1'b1; #1;
    vecs++; if (strb !== S_NONE) begin errs++; $display("FAIL timeout_16 got=%h exp=%h", strb, S_NONE); end
    @(negedge clk); next_clk = 1'b0; #1;
    vecs++; if (strb !== S_MISS) begin errs++; $display("FAIL timeout_miss got=%h exp=%h", strb, S_MISS); end
    @(negedge clk); no_lives = 1'b0; #1;
    vecs++; if (strb !== S_LCHK) begin errs++; $display("FAIL timeout_lchk got=%h exp=%h", strb, S_LCHK); end
  endtask

  task automatic test_won();
    to_judge();
    @(negedge clk); end_comp = 1'b0; match = 1'b1;
    @(negedge clk); match = 1'b0; level = 3'd7; #1;
    vecs++; if (strb !== S_NONE) begin errs++; $display("FAIL max_level got=%h exp=%h", strb, S_NONE); end
    @(negedge clk); #1;
    vecs++; if ({flags, strb} !== {F_WON, S_NONE}) begin errs++; $display("FAIL game_won got=%h exp=%h", {flags, strb}, {F_WON, S_NONE}); end
    @(negedge clk); start = 1'b1; level = 3'd0;
    @(negedge clk); start = 1'b0;
    to_judge();
    @(negedge clk); end_comp = 1'b0; match = 1'b1;
    @(negedge clk); match = 1'b0; level = 3'd2; clk_zero = 1'b1; #1;
    vecs++; if (strb !== S_NONE) begin errs++; $display("FAIL clk_zero_win got=%h exp=%h", strb, S_NONE); end
    @(negedge clk); clk_zero = 1'b0; level = 3'd0; #1;
    vecs++; if (flags !== F_WON) begin errs++; $display("FAIL clk_zero_flag got=%b exp=%b", flags, F_WON); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    to_input();
    @(negedge clk); full_input = 1'b1;
    @(negedge clk); full_input = 1'b0; #1;
    vecs++; if (strb !== S_CMP) begin errs++; $display("FAIL pre_reset_cmp got=%h exp=%h", strb, S_CMP); end
    @(negedge clk); reset = 1'b1; next_clk = 1'b1;
    @(negedge clk); reset = 1'b0; #1;
    vecs++; if ({flags, strb} !== {F_NONE, S_NONE}) begin errs++; $display("FAIL mid_reset got=%h exp=%h", {flags, strb}, {F_NONE, S_NONE}); end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); seq_end = 1'b1;
    @(negedge clk); seq_end = 1'b0; #1;
    vecs++; if ({flags, strb} !== {F_SHOW, S_NONE}) begin errs++; $display("FAIL held_next_clk got=%h exp=%h", {flags, strb}, {F_SHOW, S_NONE}); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; key_press = 1'b0; replay = 1'b0; next_clk = 1'b0;
    level = 3'd0; seq_end = 1'b0; end_comp = 1'b0; show_counter_zero = 1'b0;
    full_input = 1'b0; no_lives = 1'b0; match = 1'b0; clk_zero = 1'b0;
    test_reset();
    test_start_gen();
    test_show();
    test_input_cmp_level();
    test_replay();
    test_miss_lives();
    test_timeout();
    test_won();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/seq_game_control.md
Name: seq_game_control

Overview:
Control FSM for the number-sequence memory game. It drives the game datapath's control strobes and consumes its status flags. It sequences these phases: generate sequence → show sequence on VGA → collect user keys → compare → level-up, life loss, or game end. It also edge-detects the datapath's divided clock (next_clk) to pace the VGA display and the input timeout.

Parameters:
MAX_LEVEL, 7, level value at which a successful round ends the game as won.
TIMEOUT_TICKS, 16, number of next_clk rising edges in INPUT with no key_press before the round counts as a miss.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  pulse; starts or restarts a game from IDLE, OVER or WON
key_press  in  1  one-cycle pulse; exactly one valid key pressed (keyVal is valid at the datapath)
replay  in  1  one-cycle pulse; user requests the sequence be shown again
next_clk  in  1  divided clock level from the datapath
level  in  3  current level from the datapath
seq_end, end_comp, show_counter_zero, full_input, no_lives, match, clk_zero  in  1 each  datapath status flags
init_show_counter, reset_clk, init_lives, init_seq_counter, init_user_counter, init_level, init_match_counter  out  1 each  datapath init strobes
store_num, incr_seq_counter, incr_user_counter, read_seq, store_input, decr_show_counter, read_input, decr_lives, decr_clk, incr_level  out  1 each  datapath action strobes
show_active  out  1  high in SHOW; seq_num is meaningful to VGA
await_input  out  1  high in INPUT
game_over  out  1  high in OVER
game_won  out  1  high in WON

Behaviour:
- Registered state. All strobes are combinational from the current state and the current inputs. Flag outputs decode from state only.
- Reset: state=IDLE, tick_q=1 (this blocks a spurious tick after reset), timeout counter=0. All outputs are 0 in IDLE. Reset mid-game abandons the round immediately; the datapath is reinitialised only on the next start.
- tick = next_clk & ~tick_q. tick_q <= next_clk every cycle.
- IDLE: start → INIT.
- INIT (1 cycle): assert init_show_counter, reset_clk, init_lives, init_level, init_seq_counter, init_user_counter, init_match_counter → GEN.
- GEN:
  - While !seq_end: store_num=incr_seq_counter=1 every cycle (7 cycles).
  - On seq_end: init_seq_counter=1 → SHOW.
- SHOW:
  - On tick with !seq_end: read_seq=incr_seq_counter=1.
  - On tick with seq_end: init_seq_counter=init_user_counter=1 → INPUT.
  - Non-tick cycles assert nothing.
  - SHOW entry to exit spans 8 ticks.
- INPUT:
  - Timeout counter clears on entry and on each accepted key; it increments on each tick.
  - Priority 1, full_input: init_seq_counter=init_user_counter=init_match_counter=1 → CMP.
  - Priority 2, key_press: store_input=incr_user_counter=1.
  - Priority 3, replay with !show_counter_zero: decr_show_counter=init_seq_counter=init_user_counter=1 → SHOW. Entered keys are discarded.
  - Replay with show_counter_zero is ignored.
  - Priority 4, timeout counter == TIMEOUT_TICKS-1 and tick: → MISS.
  - Key_press and replay in the same cycle: the key is accepted and the replay is dropped.
- CMP:
  - While !end_comp: read_input=incr_user_counter=incr_seq_counter=1 each cycle.
  - On end_comp → JUDGE.
- JUDGE (1 cycle): match → LEVEL; else → MISS.
- LEVEL (1 cycle):
  - If level==MAX_LEVEL or clk_zero → WON.
  - Else: incr_level, decr_clk, init_show_counter, init_seq_counter, init_user_counter, init_match_counter → GEN.
- MISS (1 cycle): decr_lives=1 → LCHK. decr_lives is never high for more than one consecutive cycle.
- LCHK (1 cycle):
  - no_lives → OVER.
  - Else: init_show_counter, init_seq_counter, init_user_counter, init_match_counter → GEN (new sequence, same level and speed).
- OVER / WON: hold the flag. start → INIT. All other inputs are ignored.
- start outside IDLE/OVER/WON is ignored.

Test Plan:
- Reset then start: INIT strobes high for exactly 1 cycle. Then store_num high 7 cycles; with seq_end high, init_seq_counter high 1 cycle; show_active rises.
- SHOW with next_clk toggling: read_seq asserts exactly once per rising edge, 7 times. On the 8th edge → INPUT with await_input=1. No read_seq on non-edge cycles or at reset release with next_clk=1.
- INPUT: 7 key_press pulses → 7 store_input strobes. full_input → CMP → 7 read_input cycles. With match=1 and level=3 → incr_level=decr_clk=1 for 1 cycle, then back to GEN.
- Replay twice: first (show_counter_zero=0) gives decr_show_counter=1 and re-enters SHOW. Second (show_counter_zero=1) is ignored and state stays INPUT. Key_press+replay in the same cycle gives store_input only.
- Mismatch with no_lives=0 → single decr_lives pulse → GEN. With no_lives=1 at LCHK → game_over=1. A later start → INIT.
- No keys for 16 ticks in INPUT → MISS. Match at level=7 → game_won=1. Reset asserted in CMP → IDLE with all outputs 0 the next cycle.
